semaphore_axi_slave: RTL and testbench
======================================

SEMAPHORE_AXI_SLAVE -- requirements
Module: semaphore_axi_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, 32, data width; SHALL be fixed at 32.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, 6, byte-address width; decode SHALL use ADDR[5:2].
REQ-003 Parameter CNT_WIDTH, 8, semaphore counter width, legal 1..16.
REQ-004 Ports SHALL be:
- ACLK  in  1  single clock, all logic rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- AWADDR/AWPROT/AWVALID in, AWREADY out: write address channel (AWPROT ignored).
- WDATA in 32, WSTRB in 4, WVALID in, WREADY out: write data channel.
- BRESP out 2, BVALID out, BREADY in: write response channel.
- ARADDR/ARPROT/ARVALID in, ARREADY out: read address channel (ARPROT ignored).
- RDATA out 32, RRESP out 2, RVALID out, RREADY in: read data channel.
- irq  out  1  present only with SEMAPHORE_IRQ_EN (REQ-024).

Function
REQ-005 SHALL implement 4 counting semaphores, cnt[0..3], each CNT_WIDTH bits.
REQ-006 Map: 0x00-0x0C COUNT[n] R/W; 0x10-0x1C TAKE[n] RO with side effect; 0x20-0x2C GIVE[n] WO; 0x30 IRQ_PEND; 0x34-0x3C unmapped.
REQ-007 COUNT write: WSTRB[0] updates cnt bits [7:0], WSTRB[1] bits [15:8]; bits at or above CNT_WIDTH discarded; read returns cnt zero-extended.
REQ-008 TAKE read: cnt>0 -> RDATA=1, cnt decrements by 1; cnt==0 -> RDATA=0, cnt unchanged.
REQ-009 GIVE write with WSTRB!=0: cnt increments by 1, saturating at 2^CNT_WIDTH-1; WDATA ignored; reads of GIVE return 0.
REQ-010 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored; BRESP and RRESP SHALL always be 2'b00 (OKAY).
REQ-011 Write FSM states W_IDLE, W_RESP: AWREADY and WREADY high in W_IDLE; AW and W captured independently; register update in the cycle after both captured; then W_RESP with BVALID=1 held until BREADY; then W_IDLE.
REQ-012 Second AW (or W) SHALL NOT be accepted while its captured counterpart is pending or BVALID is high.
REQ-013 Read FSM states R_IDLE, R_DATA: ARREADY high in R_IDLE; on ARVALID&ARREADY, RDATA registered and RVALID=1 next cycle; RDATA and RVALID stable until RREADY; then R_IDLE.
REQ-014 Read latency from AR handshake to RVALID SHALL be exactly 1 cycle; write latency from last of AW/W handshake to BVALID exactly 2 cycles.
REQ-015 TAKE side effect SHALL occur exactly once, in the AR-handshake cycle, regardless of RREADY stall length.
REQ-016 Same-cycle TAKE and GIVE, same n: TAKE evaluates pre-cycle cnt; cnt>0 -> cnt unchanged, RDATA=1; cnt==0 -> RDATA=0, cnt becomes 1.
REQ-017 Same-cycle COUNT write and TAKE, same n: write value wins; TAKE result from pre-cycle cnt.
REQ-018 Read and write channels SHALL operate concurrently with no mutual stall.

Reset
REQ-019 ARESETN low SHALL asynchronously force cnt[0..3]=0, IRQ_PEND=0, both FSMs to idle.
REQ-020 Reset values: AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, irq=0; READY outputs rise first cycle after deassertion.
REQ-021 Reset mid-transaction SHALL abandon in-flight transfers with no counter update and no response.

Configuration
REQ-022 Macro SEMAPHORE_IRQ_EN selects interrupt support.
REQ-023 Defined: IRQ_PEND[n] sets when cnt[n] changes 0->nonzero by GIVE; write-1-to-clear via 0x30 WDATA[3:0]; same-cycle set beats clear.
REQ-024 Defined: irq = |IRQ_PEND, registered.
REQ-025 Undefined: no irq port, 0x30 reads 0, writes ignored, no pending logic.

Verification
REQ-026 Write 1,2,3,4 to 0x00,0x04,0x08,0x0C, read back -> RDATA 1,2,3,4, all RRESP=OKAY.
REQ-027 COUNT[0]=2, read TAKE[0] three times -> RDATA 1,1,0; COUNT[0] reads 0.
REQ-028 CNT_WIDTH=8, COUNT[1]=0xFF, write GIVE[1] -> COUNT[1] reads 0xFF.
REQ-029 COUNT[2]=0, same-cycle TAKE[2] and GIVE[2] -> RDATA 0, COUNT[2] reads 1; RREADY held low 10 cycles -> RVALID, RDATA stable, single decrement only.
REQ-030 ARESETN low during W_RESP with COUNT[3] write pending -> BVALID 0, COUNT[3] reads 0.
REQ-031 SEMAPHORE_IRQ_EN: GIVE[0] from 0 -> irq=1, IRQ_PEND=0x1; write 0x1 to 0x30 -> irq=0.

Source files
------------

// File: rtl/semaphore_axi_slave.sv
// AXI4-Lite slave exposing four counting semaphores through COUNT/TAKE/GIVE register windows.
// Interrupt support (IRQ_PEND register and irq port) is built only when SEMAPHORE_IRQ_EN is defined.
module semaphore_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY
`ifdef SEMAPHORE_IRQ_EN
    ,
    output logic                            irq
`endif
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e                         wstate_q;
    rstate_e                         rstate_q;
    logic                            awready_q, wready_q, bvalid_q;
    logic                            arready_q, rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic                            aw_got_q, w_got_q, upd_q;
    logic [3:0]                      awaddr_q;
    logic [15:0]                     wdata_q;
    logic [STRB_W-1:0]               wstrb_q;

    logic                            aw_hs, w_hs, ar_hs, wr_en;
    logic [CNT_WIDTH-1:0]            cnt_cur [4];
    logic [C_S_AXI_DATA_WIDTH-1:0]   rd_val;
    logic                            unused_ok;

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID && wready_q;
    assign ar_hs = ARVALID && arready_q;
    // Both halves of the write are held; the register update happens in this cycle.
    assign wr_en = aw_got_q && w_got_q;

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = 2'b00;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = 2'b00;

    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0],
                         WDATA[C_S_AXI_DATA_WIDTH-1:16]};

`ifdef SEMAPHORE_IRQ_EN
    logic [3:0] pend_cur, pend_nxt;
    logic       irq_q;
    assign irq = irq_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) irq_q <= 1'b0;
        else          irq_q <= |pend_nxt;
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sem
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic [15:0]          cur16, merged;
            logic                 take_hit, give_hit, cntw_hit;

            assign take_hit = ar_hs && (ARADDR[5:4] == 2'b01) && (ARADDR[3:2] == 2'(gi));
            assign give_hit = wr_en && (awaddr_q[3:2] == 2'b10) && (awaddr_q[1:0] == 2'(gi))
                              && (wstrb_q != '0);
            assign cntw_hit = wr_en && (awaddr_q[3:2] == 2'b00) && (awaddr_q[1:0] == 2'(gi));
            assign cur16    = 16'(cnt_q);
            assign merged   = {wstrb_q[1] ? wdata_q[15:8] : cur16[15:8],
                               wstrb_q[0] ? wdata_q[7:0]  : cur16[7:0]};
            assign cnt_cur[gi] = cnt_q;

            // A simultaneous TAKE and GIVE net out, except that an empty semaphore ends up at 1.
            always_comb begin
                cnt_d = cnt_q;
                if (cntw_hit) begin
                    cnt_d = CNT_WIDTH'(merged);
                end else if (take_hit && give_hit) begin
                    if (cnt_q == '0) cnt_d = CNT_WIDTH'(1);
                end else if (take_hit) begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_WIDTH'(1);
                end else if (give_hit) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) cnt_q <= '0;
                else          cnt_q <= cnt_d;
            end

`ifdef SEMAPHORE_IRQ_EN
            logic pend_q, pend_d, pend_set, pend_clr;
            assign pend_set = give_hit && (cnt_q == '0) && (cnt_d != '0);
            assign pend_clr = wr_en && (awaddr_q == 4'b1100) && wstrb_q[0] && wdata_q[gi];
            assign pend_d   = (pend_q && !pend_clr) || pend_set;
            assign pend_cur[gi] = pend_q;
            assign pend_nxt[gi] = pend_d;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) pend_q <= 1'b0;
                else          pend_q <= pend_d;
            end
`endif
        end
    endgenerate

    // TAKE reports the pre-handshake count; the decrement lands on the same edge.
    always_comb begin
        rd_val = '0;
        case (ARADDR[5:4])
            2'b00:   rd_val = C_S_AXI_DATA_WIDTH'(cnt_cur[ARADDR[3:2]]);
            2'b01:   rd_val = C_S_AXI_DATA_WIDTH'(cnt_cur[ARADDR[3:2]] != '0);
`ifdef SEMAPHORE_IRQ_EN
            2'b11:   if (ARADDR[3:2] == 2'b00) rd_val = C_S_AXI_DATA_WIDTH'(pend_cur);
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            upd_q     <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            upd_q <= wr_en;
            if (aw_hs) begin
                aw_got_q <= 1'b1;
                awaddr_q <= AWADDR[5:2];
            end
            if (w_hs) begin
                w_got_q <= 1'b1;
                wdata_q <= WDATA[15:0];
                wstrb_q <= WSTRB;
            end
            if (wr_en) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
            end
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= !(aw_hs || aw_got_q || upd_q);
                    wready_q  <= !(w_hs || w_got_q || upd_q);
                    if (upd_q) begin
                        wstate_q <= W_RESP;
                        bvalid_q <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        wstate_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= !ar_hs;
                    if (ar_hs) begin
                        rstate_q <= R_DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_val;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        rstate_q  <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_semaphore_axi_slave.sv
// Randomized bench for semaphore_axi_slave against a register-level model of the four semaphores.
// Interrupt checks are compiled in when SEMAPHORE_IRQ_EN is defined.
module tb_semaphore_axi_slave;

    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;
`ifdef SEMAPHORE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [5:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
`ifdef SEMAPHORE_IRQ_EN
    logic        irq;
`endif

    always #5 ACLK = ~ACLK;

    semaphore_axi_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .CNT_WIDTH(CW)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
`ifdef SEMAPHORE_IRQ_EN
        , .irq(irq)
`endif
    );

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cnt_m [4];
    logic [3:0] pend_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Reference model: reads act on the state before any write landing in the same cycle.
    task automatic model_read(input logic [5:0] a, output logic [31:0] r);
        int n;
        n = int'(a[3:2]);
        r = '0;
        case (a[5:4])
            2'b00: r = cnt_m[n];
            2'b01: if (cnt_m[n] > 0) begin r = 1; cnt_m[n] = cnt_m[n] - 1; end
            2'b11: if (IRQ_EN && n == 0) r = {28'd0, pend_m};
            default: r = '0;
        endcase
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                               input int pre);
        int n, v;
        n = int'(a[3:2]);
        case (a[5:4])
            2'b00: begin
                v = cnt_m[n];
                if (s[0]) v = (v & 32'hFF00) | int'(d[7:0]);
                if (s[1]) v = (v & 32'h00FF) | (int'(d[15:8]) << 8);
                cnt_m[n] = v & MAXV;
            end
            2'b10: if (s != 4'h0) begin
                if (cnt_m[n] < MAXV) cnt_m[n] = cnt_m[n] + 1;
                if (IRQ_EN && pre == 0 && cnt_m[n] != 0) pend_m[n] = 1'b1;
            end
            2'b11: if (IRQ_EN && n == 0 && s[0]) pend_m = pend_m & ~d[3:0];
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        pend_m = 4'h0;
    endtask

    task automatic chk_irq(input string tag);
`ifdef SEMAPHORE_IRQ_EN
        check_eq(tag, {31'd0, irq}, {31'd0, |pend_m});
`else
        $display("   (%s: irq disabled)", tag);
`endif
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int t, lat, w_hold;
        bit aw_f, w_f, aw_done, w_done;
        $display("wr  addr=0x%02h data=0x%08h strb=0x%h", a, d, s);
        AWADDR = a; WDATA = d; WSTRB = s;
        w_hold = $urandom_range(0, 2);
        aw_done = 0; w_done = 0; t = 0;
        AWVALID = 1'b1;
        WVALID  = (w_hold == 0);
        while (!(aw_done && w_done) && t < 20) begin
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            tick();
            t++;
            if (aw_f) begin AWVALID = 1'b0; aw_done = 1; end
            if (w_f)  begin WVALID  = 1'b0; w_done  = 1; end
            if (aw_done && !w_done) check_eq("awready_blocked", {31'd0, AWREADY}, 32'd0);
            if (!w_done && t >= w_hold) WVALID = 1'b1;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        check_eq("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
        lat = 0;
        while (!BVALID && lat < 10) begin tick(); lat++; end
        check_eq("b_latency", lat, 2);
        check_eq("bresp", {30'd0, BRESP}, 32'd0);
        repeat ($urandom_range(0, 3)) begin
            tick();
            check_eq("bvalid_hold", {31'd0, BVALID}, 32'd1);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check_eq("bvalid_drop", {31'd0, BVALID}, 32'd0);
    endtask

    task automatic axi_read(input logic [5:0] a, input int stall, output logic [31:0] rd);
        int t;
        bit f, done;
        ARADDR = a; ARVALID = 1'b1;
        t = 0; done = 0;
        while (!done && t < 20) begin
            f = ARVALID && ARREADY;
            tick();
            t++;
            if (f) begin ARVALID = 1'b0; done = 1; end
        end
        ARVALID = 1'b0;
        check_eq("ar_handshake", {31'd0, done}, 32'd1);
        check_eq("r_latency", {31'd0, RVALID}, 32'd1);
        check_eq("rresp", {30'd0, RRESP}, 32'd0);
        rd = RDATA;
        $display("rd  addr=0x%02h data=0x%08h", a, rd);
        repeat (stall) begin
            tick();
            check_eq("rvalid_hold", {31'd0, RVALID}, 32'd1);
            check_eq("rdata_hold", RDATA, rd);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check_eq("rvalid_drop", {31'd0, RVALID}, 32'd0);
    endtask

    task automatic do_read(input logic [5:0] a, input string tag, output logic [31:0] rd);
        logic [31:0] want;
        model_read(a, want);
        axi_read(a, $urandom_range(0, 3), rd);
        check_eq(tag, rd, want);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int pre;
        pre = cnt_m[a[3:2]];
        axi_write(a, d, s);
        model_write(a, d, s, pre);
        chk_irq("irq_after_wr");
    endtask

    // Write address/data accepted one edge before the AR handshake, so the write's
    // register update and the read's side effect share one clock edge.
    task automatic concurrent(input logic [5:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                              input logic [5:0] ra, input int stall, output logic [31:0] rd);
        logic [31:0] want;
        int pre, t;
        $display("cc  wr=0x%02h data=0x%08h strb=0x%h rd=0x%02h stall=%0d", wa, wd, ws, ra, stall);
        check_eq("cc_idle_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
        AWADDR = wa; WDATA = wd; WSTRB = ws; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = ra; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        pre = cnt_m[wa[3:2]];
        model_read(ra, want);
        model_write(wa, wd, ws, pre);
        check_eq("cc_rvalid", {31'd0, RVALID}, 32'd1);
        rd = RDATA;
        check_eq("cc_rdata", rd, want);
        repeat (stall) begin
            tick();
            check_eq("cc_rvalid_hold", {31'd0, RVALID}, 32'd1);
            check_eq("cc_rdata_hold", RDATA, rd);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        t = 0;
        while (!BVALID && t < 10) begin tick(); t++; end
        check_eq("cc_bvalid", {31'd0, BVALID}, 32'd1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk_irq("irq_after_cc");
    endtask

    initial begin
        logic [31:0] rd, d;
        logic [5:0]  wa, ra;
        logic [3:0]  s;
        int          t, op;

        ARESETN = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        model_reset();
        repeat (3) tick();
        check_eq("rst_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        check_eq("rst_valid", {30'd0, BVALID, RVALID}, 32'd0);
        check_eq("rst_rdata", RDATA, 32'd0);
        check_eq("rst_resp", {28'd0, BRESP, RRESP}, 32'd0);
        chk_irq("rst_irq");
        ARESETN = 1'b1;
        check_eq("ready_post_rst_0", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        tick();
        check_eq("ready_post_rst_1", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

        for (int i = 0; i < 4; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) begin
            do_read(6'(i * 4), "count_rb", rd);
            check_eq("count_rb_const", rd, 32'(i + 1));
        end

        do_write(6'h00, 32'd2, 4'h1);
        do_read(6'h10, "take0_a", rd); check_eq("take0_a_const", rd, 32'd1);
        do_read(6'h10, "take0_b", rd); check_eq("take0_b_const", rd, 32'd1);
        do_read(6'h10, "take0_c", rd); check_eq("take0_c_const", rd, 32'd0);
        do_read(6'h00, "count0_empty", rd); check_eq("count0_empty_const", rd, 32'd0);

        do_write(6'h04, 32'hFF, 4'h1);
        do_write(6'h24, 32'h1234, 4'h1);
        do_read(6'h04, "give_sat", rd); check_eq("give_sat_const", rd, 32'hFF);
        do_read(6'h24, "give_rd_zero", rd); check_eq("give_rd_zero_const", rd, 32'd0);
        do_read(6'h38, "unmapped_rd", rd); check_eq("unmapped_rd_const", rd, 32'd0);

        do_write(6'h08, 32'd0, 4'h1);
        concurrent(6'h28, 32'd0, 4'hF, 6'h18, 10, rd);
        check_eq("cc_tg_const", rd, 32'd0);
        do_read(6'h08, "cc_tg_count", rd); check_eq("cc_tg_count_const", rd, 32'd1);

        do_write(6'h04, 32'd5, 4'h1);
        concurrent(6'h04, 32'd9, 4'h1, 6'h14, 2, rd);
        check_eq("cc_cw_const", rd, 32'd1);
        do_read(6'h04, "cc_cw_count", rd); check_eq("cc_cw_count_const", rd, 32'd9);

`ifdef SEMAPHORE_IRQ_EN
        do_write(6'h30, 32'hF, 4'hF);
        do_write(6'h00, 32'd0, 4'h1);
        do_write(6'h20, 32'd0, 4'hF);
        check_eq("irq_set_const", {31'd0, irq}, 32'd1);
        do_read(6'h30, "irq_pend", rd); check_eq("irq_pend_const", rd, 32'h1);
        do_write(6'h30, 32'h1, 4'h1);
        check_eq("irq_clr_const", {31'd0, irq}, 32'd0);
`endif

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 3);
            wa = 6'($urandom_range(0, 15) * 4);
            ra = 6'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 1) == 1) ra[3:2] = wa[3:2];
            d  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            s  = 4'($urandom);
            case (op)
                0:       do_write(wa, d, s);
                1:       do_read(ra, "rand_rd", rd);
                default: concurrent(wa, d, s, ra, $urandom_range(0, 4), rd);
            endcase
        end

        for (int i = 0; i < 4; i++) do_read(6'(i * 4), "final_count", rd);

        // Reset while the COUNT[3] response is waiting for BREADY.
        AWADDR = 6'h0C; WDATA = 32'd7; WSTRB = 4'h1; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        t = 0;
        while (!BVALID && t < 10) begin tick(); t++; end
        check_eq("rst_mid_bvalid_pre", {31'd0, BVALID}, 32'd1);
        #2 ARESETN = 1'b0;
        #1;
        model_reset();
        check_eq("rst_mid_bvalid", {31'd0, BVALID}, 32'd0);
        check_eq("rst_mid_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        tick();
        ARESETN = 1'b1;
        tick();
        do_read(6'h0C, "rst_mid_count3", rd); check_eq("rst_mid_count3_const", rd, 32'd0);
        chk_irq("rst_mid_irq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
